// File: rtl/rsa_job_master.sv
// Client-side driver for an RSA modexp engine: queues jobs, runs them one at a time,
// and returns each result with a status code (OK, BAD_MODULUS, TIMEOUT).
module rsa_job_master #(
    parameter int MODULUS_WIDTH  = 16,
    parameter int EXPONENT_WIDTH = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [MODULUS_WIDTH-1:0]  req_message,
    input  logic [MODULUS_WIDTH-1:0]  req_modulus,
    input  logic [EXPONENT_WIDTH-1:0] req_exponent,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [MODULUS_WIDTH-1:0]  rsp_result,
    output logic [1:0]                rsp_status,
    output logic                      rsa_start,
    output logic [MODULUS_WIDTH-1:0]  rsa_message,
    output logic [MODULUS_WIDTH-1:0]  rsa_modulus,
    output logic [EXPONENT_WIDTH-1:0] rsa_exponent,
    input  logic [MODULUS_WIDTH-1:0]  rsa_result,
    input  logic                      rsa_done,
    output logic                      busy,
    output logic [15:0]               jobs_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BAD_MOD = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    logic [MODULUS_WIDTH-1:0]  msg_mem [FIFO_DEPTH];
    logic [MODULUS_WIDTH-1:0]  mod_mem [FIFO_DEPTH];
    logic [EXPONENT_WIDTH-1:0] exp_mem [FIFO_DEPTH];

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        full, empty, push;
    logic [AW-1:0] head;

    state_t                    state_q;
    logic [TW-1:0]             timer_q;
    logic                      start_q, rsp_valid_q;
    logic [1:0]                status_q;
    logic [MODULUS_WIDTH-1:0]  result_q, msg_q, mod_q;
    logic [EXPONENT_WIDTH-1:0] exp_q;
    logic [15:0]               jobs_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = req_valid && !full;
    assign head  = rd_ptr_q[AW-1:0];

    assign req_ready    = !full;
    assign busy         = (state_q != S_IDLE) || !empty;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = result_q;
    assign rsp_status   = status_q;
    assign rsa_start    = start_q;
    assign rsa_message  = msg_q;
    assign rsa_modulus  = mod_q;
    assign rsa_exponent = exp_q;
    assign jobs_done    = jobs_q;

    always_ff @(posedge clk) begin
        if (push) begin
            msg_mem[wr_ptr_q[AW-1:0]] <= req_message;
            mod_mem[wr_ptr_q[AW-1:0]] <= req_modulus;
            exp_mem[wr_ptr_q[AW-1:0]] <= req_exponent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_ptr_q <= '0;
        else if (push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            timer_q     <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            status_q    <= ST_OK;
            result_q    <= '0;
            msg_q       <= '0;
            mod_q       <= '0;
            exp_q       <= '0;
            jobs_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        msg_q    <= msg_mem[head];
                        mod_q    <= mod_mem[head];
                        exp_q    <= exp_mem[head];
                        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
                        result_q <= '0;
                        if (mod_mem[head] == '0) begin
                            status_q    <= ST_BAD_MOD;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion takes priority over a timeout landing in the same cycle.
                    if (rsa_done) begin
                        result_q    <= rsa_result;
                        status_q    <= ST_OK;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (timer_q == T_MAX) begin
                        result_q    <= '0;
                        status_q    <= ST_TIMEOUT;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_q + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        jobs_q      <= jobs_q + 16'd1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_job_master.sv
// Bench for rsa_job_master: behavioural modexp engine, scoreboard of expected responses,
// and a monitor that checks every accepted response in order.
module tb_rsa_job_master;
    localparam int MW = 16;
    localparam int EW = 4;
    localparam int TO = 64;

    logic          clk, rst;
    logic          req_valid, req_ready;
    logic [MW-1:0] req_message, req_modulus;
    logic [EW-1:0] req_exponent;
    logic          rsp_valid, rsp_ready;
    logic [MW-1:0] rsp_result;
    logic [1:0]    rsp_status;
    logic          rsa_start;
    logic [MW-1:0] rsa_message, rsa_modulus, rsa_result;
    logic [EW-1:0] rsa_exponent;
    logic          rsa_done, busy;
    logic [15:0]   jobs_done;

    rsa_job_master #(.MODULUS_WIDTH(MW), .EXPONENT_WIDTH(EW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_message(req_message), .req_modulus(req_modulus), .req_exponent(req_exponent),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_status(rsp_status),
        .rsa_start(rsa_start), .rsa_message(rsa_message), .rsa_modulus(rsa_modulus),
        .rsa_exponent(rsa_exponent), .rsa_result(rsa_result), .rsa_done(rsa_done),
        .busy(busy), .jobs_done(jobs_done)
    );

    typedef struct { logic [MW-1:0] res; logic [1:0] st; } exp_t;
    exp_t sb[$];

    int npass = 0, ntot = 0;
    int cyc = 0, acc_cyc = 0, start_cyc = 0, done_cyc = 0, nstart = 0;
    int rdy_mode = 0, stray_req = 0, stray_ack = 0;
    logic [15:0] nacc = 0;
    bit hang = 0;

    initial begin clk = 0; forever #5 clk = ~clk; end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [MW-1:0] modexp(input logic [MW-1:0] m, input logic [MW-1:0] md,
                                            input logic [EW-1:0] e);
        longint r;
        if (md == 0) return '0;
        r = 1 % longint'(md);
        for (int i = 0; i < int'(e); i++) r = (r * longint'(m)) % longint'(md);
        return MW'(r);
    endfunction

    // Behavioural engine: done exponent+2 cycles after start, unless hung.
    initial begin
        int cnt;
        logic [MW-1:0] em, emd;
        logic [EW-1:0] ee;
        cnt = 0; rsa_done = 0; rsa_result = '0;
        forever begin
            @(posedge clk); #1;
            rsa_done = 0;
            if (rst) cnt = 0;
            else begin
                if (stray_req != stray_ack) begin
                    stray_ack = stray_req;
                    rsa_done = 1; rsa_result = 16'hBEEF;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0 && !hang) begin
                        rsa_done = 1; rsa_result = modexp(em, emd, ee); done_cyc = cyc;
                    end
                end
                if (rsa_start) begin
                    nstart++; start_cyc = cyc;
                    em = rsa_message; emd = rsa_modulus; ee = rsa_exponent;
                    cnt = int'(ee) + 2;
                end
            end
        end
    end

    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       rsp_ready = 0;
                1:       rsp_ready = 1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted response.
    initial begin
        bit prev_vld;
        exp_t x;
        prev_vld = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete(); nacc = 0; prev_vld = 0;
            end else begin
                if (rsp_valid && !prev_vld && sb.size() > 0 && sb[0].st == 2'b00)
                    chk("rsp_latency", cyc, done_cyc + 1);
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) chk("rsp_unexpected", sb.size(), 1);
                    else begin
                        x = sb.pop_front();
                        chk("rsp_result", rsp_result, x.res);
                        chk("rsp_status", rsp_status, x.st);
                        chk("jobs_done_at_accept", jobs_done, nacc);
                        nacc = nacc + 16'd1;
                    end
                end
                prev_vld = rsp_valid;
            end
        end
    end

    task automatic push(input logic [MW-1:0] m, input logic [MW-1:0] md, input logic [EW-1:0] e);
        int b;
        exp_t x;
        req_message = m; req_modulus = md; req_exponent = e; req_valid = 1; b = 0;
        while (!req_ready && b < 500) begin @(posedge clk); #1; b++; end
        if (!req_ready) begin chk("push_stall", b, 0); req_valid = 0; return; end
        x.st  = (md == 0) ? 2'b01 : (hang ? 2'b10 : 2'b00);
        x.res = (x.st == 2'b00) ? modexp(m, md, e) : '0;
        sb.push_back(x);
        @(posedge clk); #1;
        acc_cyc = cyc; req_valid = 0;
    endtask

    task automatic wait_idle();
        int b = 0;
        while ((busy || rsp_valid || sb.size() != 0) && b < 4000) begin @(posedge clk); #1; b++; end
        if (b >= 4000) chk("idle_wait_expired", b, 0);
    endtask

    task automatic wait_rsp();
        int b = 0;
        while (!rsp_valid && b < 500) begin @(posedge clk); #1; b++; end
        if (!rsp_valid) chk("rsp_wait_expired", b, 0);
    endtask

    initial begin
        int n0, b;
        logic [MW-1:0] s_res, s_msg, s_mod;
        logic [1:0] s_st;
        logic [EW-1:0] s_exp;
        rst = 1; req_valid = 0; req_message = '0; req_modulus = '0; req_exponent = '0;
        repeat (3) @(posedge clk); #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsa_start", rsa_start, 0);
        chk("reset_busy", busy, 0);
        chk("reset_jobs_done", jobs_done, 0);
        rst = 0;
        @(posedge clk); #1;

        // Single job: 3^4 mod 7 = 4
        rdy_mode = 1; n0 = nstart;
        push(16'd3, 16'd7, 4'd4);
        wait_idle();
        chk("start_latency", start_cyc, acc_cyc + 1);
        chk("single_start_pulses", nstart - n0, 1);
        chk("single_jobs_done", jobs_done, 1);

        // Five back-to-back pushes with consumer stalled
        rdy_mode = 0;
        repeat (2) @(posedge clk); #1;
        for (int i = 0; i < 5; i++) push(16'(i + 2), 16'(11 + 2 * i), 4'(i + 1));
        chk("full_after_5", req_ready, 0);
        wait_rsp();
        s_res = rsp_result; s_st = rsp_status; s_msg = rsa_message; s_mod = rsa_modulus; s_exp = rsa_exponent;
        n0 = nstart;
        repeat (10) @(posedge clk); #1;
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_result", rsp_result, modexp(16'd2, 16'd11, 4'd1));
        chk("hold_result_stable", {rsp_result, 14'd0, rsp_status}, {s_res, 14'd0, s_st});
        chk("hold_operands", {rsa_message, rsa_modulus}, {s_msg, s_mod});
        chk("hold_exponent", rsa_exponent, s_exp);
        chk("hold_no_start", nstart - n0, 0);
        rdy_mode = 1;
        wait_idle();

        // Zero modulus, then a normal job: 5^3 mod 11 = 4
        n0 = nstart;
        push(16'd5, 16'd0, 4'd3);
        push(16'd5, 16'd11, 4'd3);
        wait_idle();
        chk("badmod_start_pulses", nstart - n0, 1);

        // Hung engine -> timeout
        rdy_mode = 0; hang = 1;
        repeat (2) @(posedge clk); #1;
        push(16'd9, 16'd17, 4'd2);
        wait_rsp();
        chk("timeout_cycle", cyc, start_cyc + 1 + TO);
        hang = 0; rdy_mode = 1;
        wait_idle();
        stray_req++;
        repeat (4) @(posedge clk); #1;
        chk("stray_rsp_valid", rsp_valid, 0);
        chk("stray_busy", busy, 0);
        chk("stray_jobs_done", jobs_done, nacc);

        // Reset in the middle of WAIT
        n0 = nstart; b = 0;
        push(16'd2, 16'd13, 4'd15);
        while (nstart == n0 && b < 100) begin @(posedge clk); #1; b++; end
        if (nstart == n0) chk("mid_reset_start_wait", b, 0);
        repeat (3) @(posedge clk); #1;
        rst = 1; #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_out", {rsp_result, 14'd0, rsp_status}, 0);
        chk("rst_rsa_out", {rsa_message, rsa_modulus}, 0);
        chk("rst_rsa_exp_start", {rsa_exponent, rsa_start}, 0);
        chk("rst_busy_ready", {busy, req_ready}, 2'b01);
        chk("rst_jobs_done", jobs_done, 0);
        repeat (2) @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        push(16'd2, 16'd13, 4'd5);
        wait_idle();
        chk("post_reset_jobs_done", jobs_done, 1);

        // Randomised traffic with random consumer backpressure
        rdy_mode = 2;
        for (int i = 0; i < 30; i++) begin
            logic [MW-1:0] md;
            md = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            push(16'($urandom), md, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        wait_idle();
        chk("final_jobs_done", jobs_done, nacc);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
